// File: rtl/fifo_uart_drain.sv
// Drains an 8-bit FWFT FIFO onto an async serial line: start bit, 8 data bits LSB first,
// optional even parity, 1 or 2 stop bits, with CTS-style hold-off between frames.
module fifo_uart_drain #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  input  logic        cts_n,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  output logic        tx,
  output logic        busy,
  output logic [15:0] tx_count
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  state_t      state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        busy_q;
  logic [15:0] tx_count_q;
  logic [15:0] tx_count_d;
  logic        bit_done;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  assign bit_done   = (baud_q == BAUD_LAST);
  assign tx_count_d = tx_count_q + 16'd1;

  // Pop strobe is combinational so the head word is captured on the same edge it is acked.
  assign fifo_rd  = (state_q == IDLE) & ena & ~cts_n & ~fifo_empty;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_count = tx_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      tx_count_q <= '0;
    end else begin
      if (state_q != IDLE) begin
        baud_q <= bit_done ? 16'd0 : baud_q + 16'd1;
      end
      case (state_q)
        IDLE: begin
          if (fifo_rd) begin
            shift_q <= fifo_data;
            state_q <= START;
            baud_q  <= '0;
            busy_q  <= 1'b1;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_q == 3'd7) begin
              bit_q <= '0;
              if (PARITY_EN != 0) begin
                state_q <= PARITY;
                tx_q    <= even_parity(shift_q);
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[bit_q + 3'd1];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state_q <= STOP;
            bit_q   <= '0;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
          // bit_q counts stop bits here; the line is already high.
          if (bit_done) begin
            if (bit_q == STOP_LAST) begin
              state_q    <= IDLE;
              bit_q      <= '0;
              busy_q     <= 1'b0;
              tx_count_q <= tx_count_d;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Scoreboard bench for fifo_uart_drain: two instances (8N1 and 8E2) fed from queue-modelled
// FWFT FIFOs; transmitted frames are checked cycle by cycle against queued expected bytes.
module tb_fifo_uart_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        ena;
  logic        cts_n;
  logic [7:0]  fifo_data_a, fifo_data_b;
  logic        fifo_empty_a, fifo_empty_b;
  logic        fifo_rd_a, fifo_rd_b;
  logic        tx_a, tx_b, busy_a, busy_b;
  logic [15:0] tx_count_a, tx_count_b;

  logic [7:0] q_a[$], q_b[$], exp_a[$], exp_b[$];
  int pt_a[$], pt_b[$];
  int pops_a = 0, pops_b = 0, cyc = 0;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_uart_drain #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .ena(ena), .cts_n(cts_n),
    .fifo_data(fifo_data_a), .fifo_empty(fifo_empty_a), .fifo_rd(fifo_rd_a),
    .tx(tx_a), .busy(busy_a), .tx_count(tx_count_a));

  fifo_uart_drain #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .ena(ena), .cts_n(cts_n),
    .fifo_data(fifo_data_b), .fifo_empty(fifo_empty_b), .fifo_rd(fifo_rd_b),
    .tx(tx_b), .busy(busy_b), .tx_count(tx_count_b));

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic refresh();
    fifo_empty_a = (q_a.size() == 0);
    fifo_data_a  = (q_a.size() != 0) ? q_a[0] : 8'h00;
    fifo_empty_b = (q_b.size() == 0);
    fifo_data_b  = (q_b.size() != 0) ? q_b[0] : 8'h00;
  endtask

  task automatic push(input int w, input logic [7:0] d, input bit expect_out);
    if (w == 0) begin
      q_a.push_back(d);
      if (expect_out) exp_a.push_back(d);
    end else begin
      q_b.push_back(d);
      if (expect_out) exp_b.push_back(d);
    end
    refresh();
  endtask

  function automatic logic line(input int w);
    return (w != 0) ? tx_b : tx_a;
  endfunction

  function automatic logic busy_of(input int w);
    return (w != 0) ? busy_b : busy_a;
  endfunction

  function automatic logic exp_bit(input logic [7:0] d, input int b, input int par);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par != 0 && b == 9) return ^d;
    return 1'b1;
  endfunction

  // FIFO read-port models: pop on the edge following a sampled read strobe.
  always begin
    @(negedge clk); #2;
    if (fifo_rd_a) begin
      chk("rd_a_nonempty", int'(fifo_empty_a), 0);
      @(posedge clk); #1;
      if (q_a.size() != 0) void'(q_a.pop_front());
      pops_a++;
      pt_a.push_back(cyc);
      refresh();
    end
  end

  always begin
    @(negedge clk); #2;
    if (fifo_rd_b) begin
      chk("rd_b_nonempty", int'(fifo_empty_b), 0);
      @(posedge clk); #1;
      if (q_b.size() != 0) void'(q_b.pop_front());
      pops_b++;
      pt_b.push_back(cyc);
      refresh();
    end
  end

  task automatic rx_frame(input int w);
    int cpb, par, nst, nb, bad, b;
    logic [7:0] d, got;
    logic pbit;
    bit seen;
    cpb = 4;
    par = (w != 0) ? 1 : 0;
    nst = (w != 0) ? 2 : 1;
    if ((w == 0 && exp_a.size() == 0) || (w != 0 && exp_b.size() == 0)) begin
      chk("sb_underrun", 1, 0);
      return;
    end
    d = (w == 0) ? exp_a.pop_front() : exp_b.pop_front();
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (line(w) == 1'b0) seen = 1;
    end
    if (!seen) begin
      chk("rx_timeout", 0, 1);
      return;
    end
    nb = (9 + par + nst) * cpb;
    bad = 0; got = '0; pbit = 1'b0;
    for (int k = 0; k < nb; k++) begin
      if (k != 0) @(negedge clk);
      if (line(w) !== exp_bit(d, k / cpb, par)) bad++;
      if (busy_of(w) !== 1'b1) bad++;
      if (k % cpb == cpb / 2) begin
        b = k / cpb;
        if (b >= 1 && b <= 8) got[b-1] = line(w);
        if (par != 0 && b == 9) pbit = line(w);
      end
    end
    chk("rx_glitch", bad, 0);
    chk("rx_byte", int'(got), int'(d));
    if (par != 0) chk("rx_parity", int'(pbit), int'(^d));
    @(negedge clk);
    chk("idle_tx", int'(line(w)), 1);
    chk("idle_busy", int'(busy_of(w)), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rds, lows, p0;
    bit seen;
    reset = 1'b1; ena = 1'b1; cts_n = 1'b0;
    refresh();
    repeat (3) @(negedge clk);
    chk("rst_tx_a", int'(tx_a), 1);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_rd_a", int'(fifo_rd_a), 0);
    chk("rst_cnt_a", int'(tx_count_a), 0);
    chk("rst_tx_b", int'(tx_b), 1);
    reset = 1'b0;
    @(negedge clk);

    // Single 8N1 frame of 0xA5
    push(0, 8'hA5, 1);
    rx_frame(0);
    chk("t1_cnt", int'(tx_count_a), 1);
    chk("t1_pops", pops_a, 1);

    // Back-to-back frames
    pt_a.delete();
    push(0, 8'h01, 1); push(0, 8'h02, 1); push(0, 8'h03, 1);
    rx_frame(0); rx_frame(0); rx_frame(0);
    chk("t2_npops", pt_a.size(), 3);
    if (pt_a.size() == 3) begin
      chk("t2_gap1", pt_a[1] - pt_a[0], 41);
      chk("t2_gap2", pt_a[2] - pt_a[1], 41);
    end
    chk("t2_cnt", int'(tx_count_a), 4);

    // Even parity, two stop bits
    pt_b.delete();
    push(1, 8'h07, 1); push(1, 8'h03, 1);
    rx_frame(1); rx_frame(1);
    chk("t3_npops", pt_b.size(), 2);
    if (pt_b.size() == 2) chk("t3_gap", pt_b[1] - pt_b[0], 49);
    chk("t3_cnt", int'(tx_count_b), 2);

    // ena low holds off a pending byte
    ena = 1'b0;
    p0 = pops_a;
    push(0, 8'h11, 1);
    repeat (20) @(negedge clk);
    chk("ena_hold", pops_a, p0);
    ena = 1'b1;
    rx_frame(0);

    // CTS hold-off, release, then raise mid-frame
    cts_n = 1'b1;
    push(0, 8'h5A, 1); push(0, 8'hC3, 1);
    rds = 0; lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_rd_a) rds++;
      if (!tx_a) lows++;
    end
    chk("cts_rd", rds, 0);
    chk("cts_tx", lows, 0);
    p0 = pops_a;
    cts_n = 1'b0;
    #2;
    chk("cts_release_rd", int'(fifo_rd_a), 1);
    fork
      rx_frame(0);
      begin
        @(posedge clk);
        repeat (18) @(negedge clk);
        cts_n = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    chk("cts_mid_pops", pops_a, p0 + 1);
    chk("cts_mid_left", q_a.size(), 1);
    chk("cts_mid_tx", int'(tx_a), 1);
    cts_n = 1'b0;
    rx_frame(0);
    chk("t4_cnt", int'(tx_count_a), 7);

    // Async reset during data bit 4 of 0xFF
    push(0, 8'hFF, 0);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (tx_a == 1'b0) seen = 1;
    end
    chk("t5_start_seen", int'(seen), 1);
    repeat (21) @(negedge clk);
    chk("t5_busy_pre", int'(busy_a), 1);
    #1 reset = 1'b1;
    #1;
    chk("t5_tx", int'(tx_a), 1);
    chk("t5_busy", int'(busy_a), 0);
    chk("t5_cnt", int'(tx_count_a), 0);
    chk("t5_cnt_b", int'(tx_count_b), 0);
    @(negedge clk);
    reset = 1'b0;
    rds = 0; lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fifo_rd_a) rds++;
      if (!tx_a) lows++;
    end
    chk("t5_post_rd", rds, 0);
    chk("t5_post_tx", lows, 0);

    // Counter wrap
    @(negedge clk);
    force dut_a.tx_count_q = 16'hFFFF;
    @(negedge clk);
    release dut_a.tx_count_q;
    @(negedge clk);
    chk("t6_preload", int'(tx_count_a), 32'h0000FFFF);
    push(0, 8'h3C, 1);
    rx_frame(0);
    chk("t6_wrap", int'(tx_count_a), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
